// File: rtl/m2p_pipe_arbiter.sv
// m2p_pipe_arbiter: round-robin arbiter that merges NREQ indication packers onto one
// outbound message pipe. The winner index is stamped into the source field and the
// message is queued in a 2-entry FIFO that drives the shared pipe enqueue port.
module m2p_pipe_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 144
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_enq_ena_i,
  input  logic [NREQ*WIDTH-1:0] req_enq_v_i,
  output logic [NREQ-1:0]       req_enq_rdy_o,
  output logic                  pipe_enq_ena_o,
  output logic [WIDTH-1:0]      pipe_enq_v_o,
  input  logic                  pipe_enq_rdy_i,
  output logic [31:0]           grant_count
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0]  last_q;
  logic [1:0]       count_q, count_d;
  logic             head_q, tail_q;
  logic [WIDTH-1:0] mem_q [2];
  logic [31:0]      grant_count_q;

  logic             space;
  logic             win_valid;
  logic [IdxW-1:0]  win_idx;
  logic [IdxW-1:0]  cand;
  logic [WIDTH-1:0] win_msg;
  logic             up_xfer;
  logic             down_xfer;

  // Round-robin search starting just after the last winner; blind to downstream ready.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NREQ);
      if (!win_valid && req_enq_ena_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant only with FIFO space; a full FIFO blocks even if it dequeues this cycle.
  always_comb begin
    space         = (count_q < 2'd2);
    up_xfer       = nRST && space && win_valid;
    down_xfer     = pipe_enq_ena_o && pipe_enq_rdy_i;
    req_enq_rdy_o = '0;
    if (up_xfer) begin
      req_enq_rdy_o[win_idx] = 1'b1;
    end
  end

  // Select the winner's message and overwrite its (always zero) source field.
  always_comb begin
    win_msg = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_msg = req_enq_v_i[i*WIDTH +: WIDTH];
      end
    end
    win_msg[WIDTH-1 -: 16] = 16'(win_idx);
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({up_xfer, down_xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, round-robin pointer and grant counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q       <= '0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      last_q        <= IdxW'(NREQ - 1);
      grant_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (up_xfer) begin
        tail_q        <= ~tail_q;
        last_q        <= win_idx;
        grant_count_q <= grant_count_q + 32'd1;
      end
      if (down_xfer) begin
        head_q <= ~head_q;
      end
    end
  end

  // Message storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge CLK) begin
    if (up_xfer) begin
      mem_q[tail_q] <= win_msg;
    end
  end

  // Registered outputs straight from state.
  always_comb begin
    pipe_enq_ena_o = (count_q != 2'd0);
    pipe_enq_v_o   = mem_q[head_q];
    grant_count    = grant_count_q;
  end

endmodule

// File: tb/tb_m2p_pipe_arbiter.sv
// Directed testbench for m2p_pipe_arbiter (NREQ=4, WIDTH=144).
module tb_m2p_pipe_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 144;

  logic                  CLK;
  logic                  nRST;
  logic [NREQ-1:0]       req_ena;
  logic [NREQ*WIDTH-1:0] req_v;
  logic [NREQ-1:0]       req_rdy;
  logic                  pipe_ena;
  logic [WIDTH-1:0]      pipe_v;
  logic                  pipe_rdy;
  logic [31:0]           grant_count;

  int checks   = 0;
  int failures = 0;

  m2p_pipe_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .req_enq_ena_i (req_ena),
    .req_enq_v_i   (req_v),
    .req_enq_rdy_o (req_rdy),
    .pipe_enq_ena_o(pipe_ena),
    .pipe_enq_v_o  (pipe_v),
    .pipe_enq_rdy_i(pipe_rdy),
    .grant_count   (grant_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Per-requester message as a packer would produce it: source field zero.
  function automatic logic [WIDTH-1:0] base_msg(input int i);
    return {16'h0, 8'(8'hA0 + i), 24'h5A5A5A, 32'(i * 17), 64'hFEDC_BA98_7654_3210};
  endfunction

  function automatic logic [WIDTH-1:0] stamped(input int i, input logic [WIDTH-1:0] m);
    return {16'(i), m[WIDTH-17:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic load_base();
    for (int i = 0; i < NREQ; i++) req_v[i*WIDTH +: WIDTH] = base_msg(i);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    pipe_rdy = 1'b1;
    req_ena  = 4'b1111;
    load_base();
    @(negedge CLK);
    nRST = 1'b0;
    tick();
    #1;
    checks++;
    if (req_rdy !== 4'b0000) begin
      failures++;
      $display("FAIL reset_rdy actual=%b required=0000", req_rdy);
    end
    checks++;
    if (pipe_ena !== 1'b0) begin
      failures++;
      $display("FAIL reset_pipe_ena actual=%b required=0", pipe_ena);
    end
    checks++;
    if (grant_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_grant_count actual=%0d required=0", grant_count);
    end
    req_ena = 4'b0000;
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] exp_v;
    v     = {16'd0, 16'd5, 8'd0, 32'hDEADBEEF, 8'h01, 8'h02, 8'h03, 32'd0, 16'd3};
    exp_v = {16'd2, 16'd5, 8'd0, 32'hDEADBEEF, 8'h01, 8'h02, 8'h03, 32'd0, 16'd3};
    do_reset();
    pipe_rdy = 1'b1;
    req_v[2*WIDTH +: WIDTH] = v;
    req_ena = 4'b0100;
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin
      failures++;
      $display("FAIL single_rdy actual=%b required=0100", req_rdy);
    end
    tick();
    req_ena = 4'b0000;
    #1;
    checks++;
    if (pipe_ena !== 1'b1) begin
      failures++;
      $display("FAIL single_pipe_ena actual=%b required=1", pipe_ena);
    end
    checks++;
    if (pipe_v !== exp_v) begin
      failures++;
      $display("FAIL single_pipe_v actual=%h required=%h", pipe_v, exp_v);
    end
    checks++;
    if (grant_count !== 32'd1) begin
      failures++;
      $display("FAIL single_grant_count actual=%0d required=1", grant_count);
    end
    tick();
    load_base();
  endtask

  task automatic test_contend();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    pipe_rdy = 1'b1;
    req_ena  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL contend_rdy[%0d] actual=%b required=%b", k, req_rdy, exp_rdy);
      end
      tick();
      checks++;
      if (pipe_ena !== 1'b1 || pipe_v !== stamped(k % 4, base_msg(k % 4))) begin
        failures++;
        $display("FAIL contend_out[%0d] actual=%b/%h required=1/%h", k, pipe_ena, pipe_v,
                 stamped(k % 4, base_msg(k % 4)));
      end
    end
    checks++;
    if (grant_count !== 32'd8) begin
      failures++;
      $display("FAIL contend_grant_count actual=%0d required=8", grant_count);
    end
    req_ena = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    pipe_rdy = 1'b0;
    req_ena  = 4'b0011;
    #1;
    checks++;
    if (req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL bp_rdy0 actual=%b required=0001", req_rdy);
    end
    tick();
    #1;
    checks++;
    if (req_rdy !== 4'b0010) begin
      failures++;
      $display("FAIL bp_rdy1 actual=%b required=0010", req_rdy);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (req_rdy !== 4'b0000) begin
        failures++;
        $display("FAIL bp_blocked[%0d] actual=%b required=0000", k, req_rdy);
      end
      checks++;
      if (pipe_v !== stamped(0, base_msg(0)) || grant_count !== 32'd2) begin
        failures++;
        $display("FAIL bp_hold[%0d] actual=%h/%0d required=%h/2", k, pipe_v, grant_count,
                 stamped(0, base_msg(0)));
      end
      tick();
    end
    // Downstream opens while full: this cycle must still refuse upstream.
    pipe_rdy = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 4'b0000) begin
      failures++;
      $display("FAIL full_deq_rdy actual=%b required=0000", req_rdy);
    end
    tick();
    #1;
    checks++;
    if (pipe_v !== stamped(1, base_msg(1)) || req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL bp_resume1 actual=%h/%b required=%h/0001", pipe_v, req_rdy,
               stamped(1, base_msg(1)));
    end
    tick();
    #1;
    checks++;
    if (pipe_v !== stamped(0, base_msg(0)) || req_rdy !== 4'b0010 || pipe_ena !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume2 actual=%h/%b/%b required=%h/0010/1", pipe_v, req_rdy,
               pipe_ena, stamped(0, base_msg(0)));
    end
    tick();
    #1;
    checks++;
    if (pipe_v !== stamped(1, base_msg(1)) || req_rdy !== 4'b0001 || grant_count !== 32'd4)
    begin
      failures++;
      $display("FAIL bp_resume3 actual=%h/%b/%0d required=%h/0001/4", pipe_v, req_rdy,
               grant_count, stamped(1, base_msg(1)));
    end
    req_ena = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pipe_rdy = 1'b1;
    req_ena  = 4'b1111;
    for (int k = 0; k < 6; k++) tick();
    pipe_rdy = 1'b0;
    tick();
    #1;
    checks++;
    if (grant_count !== 32'd7 || req_rdy !== 4'b0000 || pipe_ena !== 1'b1) begin
      failures++;
      $display("FAIL mid_prereset actual=%0d/%b/%b required=7/0000/1", grant_count, req_rdy,
               pipe_ena);
    end
    nRST    = 1'b0;
    req_ena = 4'b1001;
    tick();
    #1;
    checks++;
    if (pipe_ena !== 1'b0 || grant_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset actual=%b/%0d required=0/0", pipe_ena, grant_count);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL mid_first_grant actual=%b required=0001", req_rdy);
    end
    req_ena = 4'b0000;
    pipe_rdy = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    force dut.grant_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.grant_count_q;
    #1;
    checks++;
    if (grant_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preload actual=%h required=ffffffff", grant_count);
    end
    req_ena = 4'b0001;
    tick();
    req_ena = 4'b0000;
    #1;
    checks++;
    if (grant_count !== 32'd0) begin
      failures++;
      $display("FAIL wrap_count actual=%h required=00000000", grant_count);
    end
    tick();
  endtask

  initial begin
    nRST     = 1'b0;
    req_ena  = '0;
    req_v    = '0;
    pipe_rdy = 1'b0;
    test_reset();
    test_single();
    test_contend();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
